// File: rtl/pipe_alu_if.sv
// Handshake and result bundle for pipe_alu: producer-side (master) and ALU-side (slave) views.
interface pipe_alu_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             overflow;
  logic             zero;
  logic             sticky_ovf;
  logic             clr_sticky;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, A, B, opcode, out_ready, clr_sticky,
    input  in_ready, out_valid, result, carryout, overflow, zero, sticky_ovf, op_count
  );

  modport slave (
    input  in_valid, A, B, opcode, out_ready, clr_sticky,
    output in_ready, out_valid, result, carryout, overflow, zero, sticky_ovf, op_count
  );
endinterface

// File: rtl/pipe_alu.sv
// Two-stage valid/ready ALU: S1 holds operands, S2 holds result and flags.
// Also keeps a sticky overflow flag and a wrapping count of completed output transfers.
module pipe_alu #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  pipe_alu_if.slave    bus
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_fire, out_fire, s1_adv;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] res_c;
  logic             carry_c, ovf_c;
  logic             a_msb, b_msb, r_msb;

  assign bus.in_ready = !s1_valid_q || !out_valid_q || bus.out_ready;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = out_valid_q && bus.out_ready;
  // S2 is free when empty or being drained in this very cycle
  assign s1_adv       = s1_valid_q && (!out_valid_q || bus.out_ready);

  always_comb begin
    sum     = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    diff    = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    a_msb   = s1_a_q[WIDTH-1];
    b_msb   = s1_b_q[WIDTH-1];
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    unique case (s1_op_q)
      3'd0: begin res_c = sum[WIDTH-1:0];  carry_c = sum[WIDTH];  ovf_c = sum[WIDTH];  end
      3'd1: begin
        res_c   = sum[WIDTH-1:0];
        carry_c = sum[WIDTH];
        ovf_c   = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
      end
      3'd2: begin res_c = diff[WIDTH-1:0]; carry_c = diff[WIDTH]; ovf_c = diff[WIDTH]; end
      3'd3: begin
        res_c   = diff[WIDTH-1:0];
        carry_c = diff[WIDTH];
        ovf_c   = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb);
      end
      3'd4: res_c = s1_a_q & s1_b_q;
      3'd5: res_c = s1_a_q | s1_b_q;
      3'd6: res_c = s1_a_q ^ s1_b_q;
      3'd7: begin res_c = {a_msb, s1_a_q[WIDTH-1:1]}; carry_c = s1_a_q[0]; end
      default: ;
    endcase
    r_msb = res_c[WIDTH-1];
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_op_d     = s1_op_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_a_d     = bus.A;
      s1_b_d     = bus.B;
      s1_op_d    = bus.opcode;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      out_valid_d = 1'b1;
      result_d    = res_c;
      carry_d     = carry_c;
      ovf_d       = ovf_c;
      zero_d      = (res_c == '0);
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end

    // Clear first so that a same-cycle overflow transfer wins
    if (bus.clr_sticky)     sticky_d = 1'b0;
    if (out_fire && ovf_q)  sticky_d = 1'b1;
    if (out_fire)           cnt_d    = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;
  assign bus.carryout   = carry_q;
  assign bus.overflow   = ovf_q;
  assign bus.zero       = zero_q;
  assign bus.sticky_ovf = sticky_q;
  assign bus.op_count   = cnt_q;

  logic unused_r_msb;
  assign unused_r_msb = r_msb;

endmodule
